cache_dm_param: RTL and testbench

Parametrised, single-clock, direct-mapped, write-through, no-write-allocate cache between the CPU load/store path and the MCU memory port.
- Generalises the fixed 256-entry, 2-word-line CPU cache.
- Line depth and line length are set by parameters.
- Memory fills are multi-beat bursts of any length.
- Adds a hardware invalidate-all sweep, run automatically after reset and on request.

---
 rtl/cache_dm_param.sv | 189 ++++++++++++++++++
 tb/tb_cache_dm_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_param.sv
// cache_dm_param: parametrised direct-mapped, write-through, no-write-allocate cache with
// multi-beat line fills and an invalidate-all sweep that runs after reset or on request.
module cache_dm_param #(
    parameter int IDX_BITS        = 8,
    parameter int LINE_WORDS_LOG2 = 1,
    parameter int MEM_ADDR_BITS   = 26
) (
    input  logic                     CPU_CLK,
    input  logic                     RST,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_ready,
    input  logic                     inv_all,
    output logic                     flush_busy,
    output logic                     mem_do_act,
    output logic                     mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [31:0]              mem_dataintomem,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_datafrommem
);
    localparam int W  = LINE_WORDS_LOG2;
    localparam int DW = IDX_BITS + W;
    localparam int TW = 30 - DW;

    typedef enum logic [2:0] {INVAL, IDLE, LOOKUP, FILL, WRITE} state_t;
    state_t state, state_n;

    logic [31:0] data_ram [2**DW];
    logic [TW:0] tag_ram [2**IDX_BITS];
    logic [31:0] data_q;
    logic [TW:0] tag_q;

    logic [29:0] addr_q, addr_n;
    logic we_q, we_n;
    logic [31:0] wdata_q, wdata_n;
    logic [IDX_BITS-1:0] sweep, sweep_n;
    logic [W-1:0] beat, beat_n;
    logic acked, acked_n, inv_pend, inv_pend_n;
    logic [31:0] rdata_n, mdata_n;
    logic ready_n, do_act_n, mwe_n;
    logic [MEM_ADDR_BITS-1:0] maddr_n;
    logic hit, beat_ok, tag_we, data_we;
    logic [IDX_BITS-1:0] tag_wa;
    logic [TW:0] tag_wd;
    logic [DW-1:0] data_wa;
    logic [31:0] data_wd;
    logic [29:0] line_base;
    logic addr_unused;

    assign addr_unused = ^cpu_addr[1:0];
    assign line_base   = {addr_q[29:W], {W{1'b0}}};
    assign hit         = tag_q[TW] && tag_q[TW-1:0] == addr_q[29:DW];
    assign beat_ok     = mem_rvalid && (acked || mem_ack);
    assign tag_wa      = state == INVAL ? sweep : addr_q[DW-1:W];
    assign tag_wd      = state == INVAL ? '0 : {1'b1, addr_q[29:DW]};
    assign data_wa     = state == FILL ? {addr_q[DW-1:W], beat} : addr_q[DW-1:0];
    assign data_wd     = state == FILL ? mem_datafrommem : wdata_q;

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        we_n       = we_q;
        wdata_n    = wdata_q;
        sweep_n    = sweep;
        beat_n     = beat;
        acked_n    = acked;
        inv_pend_n = inv_pend || inv_all;
        rdata_n    = cpu_rdata;
        ready_n    = 1'b0;
        do_act_n   = mem_do_act;
        mwe_n      = mem_we;
        maddr_n    = mem_addr;
        mdata_n    = mem_dataintomem;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        case (state)
            INVAL: begin
                tag_we  = 1'b1;
                sweep_n = sweep + 1'b1;
                state_n = sweep == '1 ? IDLE : INVAL;
            end
            IDLE: begin
                // cpu_ready still high means the CPU has not yet dropped the finished request
                if (inv_all || inv_pend) begin
                    state_n    = INVAL;
                    inv_pend_n = 1'b0;
                end else if (cpu_req && !cpu_ready && !flush_busy) begin
                    state_n = LOOKUP;
                    addr_n  = cpu_addr[31:2];
                    we_n    = cpu_we;
                    wdata_n = cpu_wdata;
                end
            end
            LOOKUP: begin
                if (!we_q && hit) begin
                    ready_n = 1'b1;
                    rdata_n = data_q;
                    state_n = IDLE;
                end else begin
                    data_we  = we_q && hit;
                    do_act_n = 1'b1;
                    mwe_n    = we_q;
                    maddr_n  = MEM_ADDR_BITS'(we_q ? addr_q : line_base);
                    mdata_n  = wdata_q;
                    acked_n  = 1'b0;
                    beat_n   = '0;
                    state_n  = we_q ? WRITE : FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    do_act_n = 1'b0;
                    acked_n  = 1'b1;
                end
                if (beat_ok) begin
                    data_we = 1'b1;
                    beat_n  = beat + 1'b1;
                    if (beat == addr_q[W-1:0])
                        rdata_n = mem_datafrommem;
                    if (beat == '1) begin
                        tag_we  = 1'b1;
                        ready_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    do_act_n = 1'b0;
                    mwe_n    = 1'b0;
                    ready_n  = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = INVAL;
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            state           <= INVAL;
            sweep           <= '0;
            beat            <= '0;
            acked           <= 1'b0;
            inv_pend        <= 1'b0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            cpu_rdata       <= '0;
            cpu_ready       <= 1'b0;
            flush_busy      <= 1'b0;
            mem_do_act      <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_dataintomem <= '0;
        end else begin
            state           <= state_n;
            sweep           <= sweep_n;
            beat            <= beat_n;
            acked           <= acked_n;
            inv_pend        <= inv_pend_n;
            addr_q          <= addr_n;
            we_q            <= we_n;
            wdata_q         <= wdata_n;
            cpu_rdata       <= rdata_n;
            cpu_ready       <= ready_n;
            flush_busy      <= state == INVAL;
            mem_do_act      <= do_act_n;
            mem_we          <= mwe_n;
            mem_addr        <= maddr_n;
            mem_dataintomem <= mdata_n;
        end
    end

    // RAMs carry no reset; valid bits are cleared by the sweep instead
    always_ff @(posedge CPU_CLK) begin
        data_q <= data_ram[cpu_addr[DW+1:2]];
        tag_q  <= tag_ram[cpu_addr[DW+1:W+2]];
        if (RST && data_we)
            data_ram[data_wa] <= data_wd;
        if (RST && tag_we)
            tag_ram[tag_wa] <= tag_wd;
    end
endmodule

// File: tb/tb_cache_dm_param.sv
// tb_cache_dm_param: directed and random loads/stores checked against a memory-backed
// reference model of a direct-mapped, write-through, no-write-allocate cache.
module tb_cache_dm_param;
    localparam int IB = 8;
    localparam int WL = 1;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, inv_all = 1'b0, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_datafrommem = '0;
    logic [31:0] cpu_rdata, mem_dataintomem;
    logic cpu_ready, flush_busy, mem_do_act, mem_we;
    logic [25:0] mem_addr;
    int total = 0;
    int bad = 0;
    int w;
    bit mv [256];
    logic [20:0] mt [256];
    logic [31:0] mem [logic [29:0]];

    cache_dm_param dut (
        .CPU_CLK(clk), .RST(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .inv_all(inv_all),
        .flush_busy(flush_busy), .mem_do_act(mem_do_act), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_dataintomem(mem_dataintomem), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_datafrommem(mem_datafrommem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
    endfunction

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input bit inv);
        logic [29:0] wa, base;
        logic [20:0] tg;
        int idx, cyc, beat, wait_ack, flush_cnt;
        bit exp_hit, done, acked, seen, just_acked, last_sent;
        wa = addr[31:2];
        base = (wa >> WL) << WL;
        idx = int'((wa >> WL) % (1 << IB));
        tg = 21'(wa >> (IB + WL));
        if (inv)
            foreach (mv[i]) mv[i] = 1'b0;
        exp_hit = !we && mv[idx] && mt[idx] == tg;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; inv_all = inv;
        done = 0; acked = 0; seen = 0; just_acked = 0; last_sent = 0;
        cyc = 0; beat = 0; flush_cnt = 0;
        wait_ack = int'($urandom_range(0, 2));
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            inv_all = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_datafrommem = $urandom;
            if (flush_busy) flush_cnt++;
            if (just_acked) begin
                chk("ack_drop", mem_do_act, 0);
                if (we) chk("wr_done", cpu_ready, 1);
                just_acked = 0;
            end
            if (last_sent) begin
                chk("fill_done", cpu_ready, 1);
                last_sent = 0;
            end
            if (cpu_ready) done = 1;
            else if (mem_do_act && !acked) begin
                if (!seen) begin
                    seen = 1;
                    chk("mem_we", mem_we, we);
                    chk("mem_addr", mem_addr, 26'(we ? wa : base));
                    if (we) chk("mem_wdata", mem_dataintomem, wd);
                end
                if (wait_ack == 0) begin
                    mem_ack = 1'b1; acked = 1; just_acked = 1;
                end else wait_ack--;
            end else if (acked && !we && beat < LW && $urandom_range(0, 1) == 1) begin
                mem_rvalid = 1'b1;
                mem_datafrommem = memval(30'(base + beat));
                beat++;
                last_sent = beat == LW;
            end
        end
        cpu_req = 1'b0; inv_all = 1'b0;
        chk("done", done, 1);
        chk("bus_used", seen, we || !exp_hit);
        if (inv) chk("flush_len", flush_cnt, 256);
        if (!we) begin
            chk("rdata", cpu_rdata, memval(wa));
            if (exp_hit) chk("hit_lat", cyc, 2);
            else begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end else mem[wa] = wd;
    endtask

    task automatic do_reset(input bit late);
        int cnt, cyc;
        bit stray;
        rst_n = 1'b0; cpu_req = 1'b0; inv_all = 1'b0; mem_ack = late; mem_rvalid = late;
        @(negedge clk);
        chk("rst_ctl", {cpu_ready, mem_do_act, mem_we, flush_busy}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_maddr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b0;
        cnt = 0; cyc = 0; stray = 0;
        while (cyc < 400 && !(cnt > 0 && !flush_busy)) begin
            @(negedge clk);
            cyc++;
            mem_rvalid = late && cyc < 8;
            mem_datafrommem = $urandom;
            if (flush_busy) cnt++;
            if (cpu_ready || mem_do_act) stray = 1;
        end
        mem_rvalid = 1'b0;
        chk("sweep_len", cnt, 256);
        chk("sweep_quiet", stray, 0);
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    initial begin
        mem[30'h40] = 32'hAAAA0000;
        mem[30'h41] = 32'hAAAA0001;
        do_reset(0);
        access(0, 32'h100, 0, 0);
        access(0, 32'h104, 0, 0);
        access(1, 32'h100, 32'h12345678, 0);
        access(0, 32'h100, 0, 0);
        access(1, 32'h2000, 32'hCAFEF00D, 0);
        access(0, 32'h2000, 0, 0);
        access(0, 32'h900, 0, 0);
        access(0, 32'h100, 0, 0);
        access(0, 32'h104, 0, 1);
        access(0, 32'h100, 0, 0);
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 3) |
                ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            access($urandom_range(0, 2) == 0, a, $urandom, n % 25 == 24);
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000;
        w = 0;
        while (!mem_do_act && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midfill_req", mem_do_act, 1);
        chk("midfill_addr", mem_addr, 26'h1000);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("midfill_drop", mem_do_act, 0);
        mem_rvalid = 1'b1; mem_datafrommem = 32'hDEAD0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        do_reset(1);
        access(0, 32'h4004, 0, 0);
        access(0, 32'h4000, 0, 0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000; cpu_wdata = 32'h55AA55AA;
        w = 0;
        while (!mem_do_act && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midwrite_req", mem_do_act, 1);
        do_reset(1);
        access(0, 32'h100, 0, 0);
        access(0, 32'h104, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
